sim_watchdog: RTL and testbench

SIM_WATCHDOG -- requirements
Module: sim_watchdog

---
 rtl/sim_watchdog_pkg.sv | 14 +
 rtl/sim_watchdog_counter.sv | 37 +++
 rtl/sim_watchdog.sv | 110 +++++++++++
 tb/tb_sim_watchdog.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sim_watchdog_pkg.sv
// Shared types and default constants for the simulation watchdog.
package sim_watchdog_pkg;

  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1000;
  localparam int unsigned DEF_PROGRESS_CYCLES = 100;
  localparam int unsigned DEF_CNT_W           = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/sim_watchdog_counter.sv
// Clearable, enabled up-counter with optional wrap at LIMIT-1 and optional saturation.
module wdog_counter #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 2,
  parameter bit          WRAP  = 1'b0,
  parameter bit          SAT   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         at_limit_c
);

  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);
  localparam logic [W-1:0] MAX    = {W{1'b1}};

  assign at_limit_c = (value == LIM_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      if (WRAP && at_limit_c) begin
        value <= '0;
      end else if (SAT && (value == MAX)) begin
        value <= value;
      end else begin
        value <= value + W'(1);
      end
    end
  end

endmodule

// File: rtl/sim_watchdog.sv
// Kickable simulation watchdog: IDLE/RUN/EXPIRED FSM with timeout, progress and elapsed counts.
// Build option: define SIM_WATCHDOG_PROGRESS_EN to build the progress counter and progress_tick.
module sim_watchdog
  import sim_watchdog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned PROGRESS_CYCLES = DEF_PROGRESS_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             kick,
  output logic             kick_ack,
  output logic             running,
  output logic             expired,
  output logic             progress_tick,
  output logic [CNT_W-1:0] elapsed
);

  state_t           state;
  state_t           state_next;
  logic             arm;
  logic             in_run;
  logic             to_at_limit;
  logic             el_at_limit;
  logic [CNT_W-1:0] to_count;
  logic             unused_ok;

  assign in_run = (state == RUN);
  assign arm    = (state == IDLE) && start && !stop;

  // Stop outranks expiry; a kick in the expiry cycle cancels it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !stop) state_next = RUN;
      RUN: begin
        if (stop)                        state_next = IDLE;
        else if (!kick && to_at_limit)   state_next = EXPIRED;
      end
      EXPIRED: state_next = EXPIRED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      expired  <= 1'b0;
      kick_ack <= 1'b0;
    end else begin
      running  <= (state_next == RUN);
      expired  <= (state_next == EXPIRED);
      kick_ack <= in_run && kick;
    end
  end

  wdog_counter #(
    .W(CNT_W), .LIMIT(TIMEOUT_CYCLES), .WRAP(1'b0), .SAT(1'b1)
  ) u_timeout (
    .clk(clk), .rst(rst), .clr(arm || (in_run && kick)), .en(in_run),
    .value(to_count), .at_limit_c(to_at_limit)
  );

  wdog_counter #(
    .W(CNT_W), .LIMIT(1), .WRAP(1'b0), .SAT(1'b1)
  ) u_elapsed (
    .clk(clk), .rst(rst), .clr(arm), .en(in_run),
    .value(elapsed), .at_limit_c(el_at_limit)
  );

`ifdef SIM_WATCHDOG_PROGRESS_EN
  logic             prog_wrap;
  logic [CNT_W-1:0] prog_count;

  wdog_counter #(
    .W(CNT_W), .LIMIT(PROGRESS_CYCLES), .WRAP(1'b1), .SAT(1'b0)
  ) u_progress (
    .clk(clk), .rst(rst), .clr(arm), .en(in_run),
    .value(prog_count), .at_limit_c(prog_wrap)
  );

  // Tick lands in the cycle after the counter wraps to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      progress_tick <= 1'b0;
    end else begin
      progress_tick <= in_run && prog_wrap;
    end
  end

  assign unused_ok = ^{to_count, el_at_limit, prog_count};
`else
  localparam int unsigned unused_prog_cycles = PROGRESS_CYCLES;

  assign progress_tick = 1'b0;
  assign unused_ok     = ^{to_count, el_at_limit};
`endif

endmodule

// File: tb/tb_sim_watchdog.sv
// Self-checking bench for sim_watchdog (TIMEOUT=16, PROGRESS=4, CNT_W=8) against a behavioural model.
module tb_sim_watchdog;

  localparam int T = 16;
  localparam int P = 4;
  localparam int W = 8;
  localparam int EL_MAX = 255;

  logic         clk = 1'b0;
  logic         rst, start, stop, kick;
  logic         kick_ack, running, expired, progress_tick;
  logic [W-1:0] elapsed;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ack   = 0;
  int n_tick  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model state: armed flag, timed-out flag, unkicked cycles, RUN cycles.
  bit m_run, m_exp, e_ack, e_tick;
  int m_quiet, m_runs, m_total;

  sim_watchdog #(
    .TIMEOUT_CYCLES(T), .PROGRESS_CYCLES(P), .CNT_W(W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .kick(kick),
    .kick_ack(kick_ack), .running(running), .expired(expired),
    .progress_tick(progress_tick), .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model();
    e_ack  = 1'b0;
    e_tick = 1'b0;
    if (rst) begin
      m_run = 0; m_exp = 0; m_quiet = 0; m_runs = 0; m_total = 0;
    end else if (m_run) begin
      e_ack   = kick;
      m_total = m_total + 1;
      m_runs  = m_runs + 1;
      if (m_runs % P == 0) e_tick = 1'b1;
      if (stop) m_run = 0;
      else if (kick) m_quiet = 0;
      else begin
        m_quiet = m_quiet + 1;
        if (m_quiet >= T) begin m_run = 0; m_exp = 1; end
      end
    end else if (!m_exp && start && !stop) begin
      m_run = 1; m_quiet = 0; m_runs = 0; m_total = 0;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic p, input logic k);
    rst = r; start = s; stop = p; kick = k;
    @(posedge clk);
    model();
    @(negedge clk);
    if (kick_ack) n_ack++;
    if (progress_tick) n_tick++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic until_expired(input int limit, output int n);
    n = 0;
    while (!expired && n < limit) begin
      step(0, 0, 0, 0);
      n++;
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_running"}, int'(running), 0);
    cmp({tag, "_expired"}, int'(expired), 0);
    cmp({tag, "_kick_ack"}, int'(kick_ack), 0);
    cmp({tag, "_tick"}, int'(progress_tick), 0);
    cmp({tag, "_elapsed"}, int'(elapsed), 0);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_running", int'(running), int'(m_run));
      cmp("m_expired", int'(expired), int'(m_exp));
      cmp("m_kick_ack", int'(kick_ack), int'(e_ack));
`ifdef SIM_WATCHDOG_PROGRESS_EN
      cmp("m_tick", int'(progress_tick), int'(e_tick));
`else
      cmp("m_tick", int'(progress_tick), 0);
`endif
      cmp("m_elapsed", int'(elapsed), (m_total > EL_MAX) ? EL_MAX : m_total);
    end
  end

  initial begin
    int n;
    int exp_ticks;
`ifdef SIM_WATCHDOG_PROGRESS_EN
    exp_ticks = 25;
`else
    exp_ticks = 0;
`endif
    rst = 1; start = 0; stop = 0; kick = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_en = 1'b1;
    check_zero("reset");

    // Unkicked run: expiry 16 cycles after running rises.
    step(0, 1, 0, 0);
    cmp("start_running", int'(running), 1);
    until_expired(40, n);
    cmp("unkicked_latency", n, 16);
    cmp("unkicked_elapsed", int'(elapsed), 16);
    cmp("unkicked_running", int'(running), 0);

    // Inputs ignored in EXPIRED, then reset out of it.
    n_ack = 0;
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    step(0, 1, 0, 0);
    cmp("exp_no_ack", n_ack, 0);
    cmp("exp_hold", int'(expired), 1);
    cmp("exp_elapsed_hold", int'(elapsed), 16);
    step(1, 1, 0, 1);
    check_zero("rst_expired");
    idle_steps(3);
    cmp("post_rst_idle", int'(running), 0);

    // Periodic kicks for 100 RUN cycles.
    step(0, 1, 0, 0);
    n_ack = 0; n_tick = 0;
    for (int i = 1; i <= 100; i++) step(0, 0, 0, (i % 10 == 0));
    cmp("periodic_acks", n_ack, 10);
    cmp("periodic_ticks", n_tick, exp_ticks);
    cmp("periodic_expired", int'(expired), 0);

    // Kick exactly at count 15, then expiry 16 cycles later.
    idle_steps(15);
    step(0, 0, 0, 1);
    cmp("boundary_no_exp", int'(expired), 0);
    until_expired(40, n);
    cmp("boundary_latency", n, 16);

    // Stop coinciding with expiry: stop wins.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    idle_steps(15);
    step(0, 0, 1, 0);
    cmp("stop_exp_expired", int'(expired), 0);
    cmp("stop_exp_running", int'(running), 0);
    cmp("stop_exp_elapsed", int'(elapsed), 16);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    cmp("start_stop_idle", int'(running), 0);
    cmp("idle_elapsed_hold", int'(elapsed), 16);

    // Reset mid-RUN at count 7.
    step(0, 1, 0, 0);
    idle_steps(7);
    step(1, 0, 0, 1);
    check_zero("rst_midrun");
    idle_steps(2);
    cmp("rst_midrun_idle", int'(running), 0);

    // Elapsed saturation.
    step(0, 1, 0, 0);
    for (int i = 1; i <= 300; i++) step(0, 0, 0, (i % 10 == 0));
    cmp("elapsed_sat", int'(elapsed), 255);
    cmp("sat_running", int'(running), 1);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(199) == 0),
           ($urandom_range(9) == 0),
           ($urandom_range(29) == 0),
           ($urandom_range(7) == 0));
      if (expired && $urandom_range(19) == 0) step(1, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
